// File: rtl/bitxor_pkg.sv
// Shared types and helpers for the differential (XOR-feedback) serial decoder.
package bitxor_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Words narrower than 32 bits are passed zero-extended, which leaves parity unchanged.
  function automatic logic word_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/xor_diff_stage.sv
// Inverse of the encoder feedback stage: dbit = q[n] ^ q[n-1], with sync forcing q[n-1] to 0.
module xor_diff_stage (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  input  logic sync,
  output logic dbit
);

  logic prev_q;

  assign dbit = in_bit ^ (prev_q & ~sync);

  // Held across in_valid=0 gaps so idle cycles are transparent to the decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else if (in_valid) begin
      prev_q <= in_bit;
    end
  end

endmodule

// File: rtl/diff_deser_decoder.sv
// Differential serial decoder: recovers d[n] = q[n] ^ q[n-1] and packs bits LSB first into
// WIDTH-bit words behind a one-word valid/ready buffer with parity and sticky overflow.
module diff_deser_decoder
  import bitxor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             sync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_parity_q, out_parity_d;
  logic             overflow_q, overflow_d;

  logic             dbit;
  logic [CntW-1:0]  idx;
  logic [WIDTH-1:0] word;
  logic [31:0]      par_in;
  logic             complete;
  logic             load;

  xor_diff_stage u_diff (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .sync     (sync),
    .dbit     (dbit)
  );

  // Word as it stands after this cycle's bit; sync drops any partial word.
  always_comb begin
    idx  = sync ? '0 : bit_cnt_q;
    word = sync ? '0 : shift_q;
    word[idx] = dbit;
    complete  = in_valid && (idx == LastIdx);
    load      = complete && (!out_valid_q || out_ready);
    par_in    = '0;
    par_in[WIDTH-1:0] = word;
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (in_valid) begin
      shift_d   = word;
      bit_cnt_d = (idx == LastIdx) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    overflow_d   = overflow_q;

    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = word;
      out_parity_d = word_parity(par_in);
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end

    // A set in the same cycle as a clear takes priority.
    if (complete && out_valid_q && !out_ready) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/diff_deser_decoder.md
Name: diff_deser_decoder

Overview:
- Receive side of the bit-serial XOR-feedback (differential) encoder. The encoder sends q[n] = d[n] ^ q[n-1], with q = 0 out of reset.
- This block recovers d[n] = q[n] ^ q[n-1] and packs the decoded bits into WIDTH-bit words, LSB first.
- Each word is presented with a valid/ready handshake through a one-word output buffer. Word parity and a sticky overflow flag are provided.
- Sits between the serial link pin and word-level consumers.

Parameters:
- WIDTH, 8, bits per output word (legal range 2..32).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bit is valid this cycle. No backpressure: the serial stream is always accepted.
- in_bit  in  1  encoded serial bit q[n].
- sync  in  1  word/phase restart. Qualified with in_valid.
- out_valid  out  1  out_data/out_parity hold a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  decoded word, bit 0 = first decoded bit.
- out_parity  out  1  XOR of all bits of out_data.
- overflow  out  1  sticky: a completed word was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (reset low, asynchronous), all registers cleared:
  - outputs: out_valid=0, out_data=0, out_parity=0, overflow=0
  - internal: prev=0, bit_cnt=0, shift=0, state=IDLE
- Decode, on each cycle with in_valid=1:
  - dbit = in_bit ^ prev_eff
  - prev_eff = 0 if sync=1, else prev
  - then prev <= in_bit
- Shift/count:
  - shift[bit_cnt] <= dbit
  - bit_cnt increments, wrapping WIDTH-1 -> 0.
  - If sync=1, the current bit is stored at position 0 and bit_cnt <= 1. Any partial word is discarded silently, with no overflow.
- FSM states:
  - IDLE: no bits collected since reset/sync. Goes to RUN on the first in_valid.
  - RUN: collecting a word.
  - A word completes when the accepted bit lands at index WIDTH-1. The FSM stays in RUN and the next bit starts a new word at index 0.
  - sync in RUN restarts the count but keeps the FSM in RUN.
- Output buffer:
  - On word completion at cycle N, out_data is loaded with the full word (including the bit of cycle N) and out_parity with its reduction-XOR. out_valid=1 from cycle N+1, so latency is 1 cycle from the last bit.
  - The word loads if out_valid=0 or (out_valid & out_ready) in cycle N. Completion coinciding with a drain loads the new word back-to-back, and out_valid stays 1.
  - If out_valid=1 and out_ready=0 at completion, the new word is dropped, overflow <= 1, and the buffered word is kept unchanged.
  - While out_valid=1 and out_ready=0, out_data and out_parity are stable.
  - out_valid falls the cycle after out_valid & out_ready when no new word is loading.
- overflow:
  - Set as above. Cleared by clr_ovf=1.
  - If set and clear happen in the same cycle, set wins.
- in_valid=0 cycles: no state change. prev is held, so gaps in the stream are transparent.
- Reset mid-word: partial word, buffered word and overflow are all lost. Decoding resumes with prev=0, matching the encoder's own reset state.
- Width rules: bit_cnt is clog2(WIDTH) bits. Parity is computed combinationally from the word being loaded and stored in a register.

Decomposition:
- Package bitxor_pkg holds:
  - the default word width constant
  - the state enum {IDLE, RUN}
  - a parity helper function
- One natural sub-module, xor_diff_stage. It contains the prev flip-flop (async active-low reset to 0) plus the XOR and sync override, and outputs dbit. It is the inverse of the encoder's feedback stage and is reusable standalone.

Test Plan:
- Reset, then encoded bits 1,1,0,0,0,1,1,0 on consecutive in_valid cycles with out_ready=1 -> out_data=0xA5, out_parity=0, out_valid high for exactly one cycle, one cycle after the 8th bit.
- Continue directly with 1,1,1,1,1,1,1,1 (prev=0 after the previous word) -> out_data=0x01, out_parity=1. Then repeat the same stream with idle in_valid=0 gaps between bits -> identical result.
- Hold out_ready=0 through two full words (0xA5 then 0x01) -> out_data stays 0xA5, overflow=1. Pulse clr_ovf -> overflow=0. Raise out_ready -> out_valid drops the next cycle.
- Send 5 bits, then assert sync with encoded bits 1,1,0,0,0,1,1,0 -> partial word discarded, out_data=0xA5, overflow=0.
- Word completes in the same cycle as out_ready drains the previous word -> out_valid stays 1, out_data updates with no bubble, overflow=0.
- Assert reset for 2 cycles mid-word with out_valid=1 and overflow=1 -> all outputs 0 immediately (asynchronous). The next 8 bits decode with prev=0.
